// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the valid/ready stream port of fifo_stream_reader.
// The master modport is the reader; slave is the FIFO/stream environment.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  // FIFO read side
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  fifo_empty_i;
  logic                  fifo_rd_en_o;

  // Stream side
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;

  modport master (
    input  fifo_rd_data_i,
    input  fifo_empty_i,
    output fifo_rd_en_o,
    output m_data_o,
    output m_valid_o,
    input  m_ready_i
  );

  modport slave (
    output fifo_rd_data_i,
    output fifo_empty_i,
    input  fifo_rd_en_o,
    input  m_data_o,
    input  m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// Moves words from a 1-cycle-latency FIFO read port onto a valid/ready stream.
// Define FIFO_READER_SKID_EN for a 2-entry buffer (full rate); otherwise 1 entry (half rate).
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  fifo_stream_reader_if.master bus
);

  if (DATA_WIDTH == 0) begin : g_bad_width
    $error("fifo_stream_reader: DATA_WIDTH must be at least 1");
  end

`ifdef FIFO_READER_SKID_EN
  localparam logic [1:0] Cap = 2'd2;
`else
  localparam logic [1:0] Cap = 2'd1;
`endif

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
`ifdef FIFO_READER_SKID_EN
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
`endif

  logic       pop;
  logic       rd_en;
  logic [2:0] level;

  assign pop = (occ_q != 2'd0) & bus.m_ready_i;

  // Occupancy after this edge if no new read is issued; bounds the read request.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign rd_en = rst_n & ~flush_i & ~bus.fifo_empty_i & (level < {1'b0, Cap});

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = (occ_q != 2'd0);
  assign bus.m_data_o     = head_q;

  always_comb begin
    occ_d      = occ_q;
    inflight_d = rd_en;
    head_d     = head_q;
`ifdef FIFO_READER_SKID_EN
    tail_d     = tail_q;
`endif
    if (flush_i) begin
      // Flush wins over capture; the arriving word is dropped.
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      occ_d = level[1:0];
`ifdef FIFO_READER_SKID_EN
      if (pop && (occ_q == 2'd2)) begin
        head_d = tail_q;
      end
      if (inflight_q) begin
        // Capture lands in the first entry left free after this cycle's pop.
        if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
          head_d = bus.fifo_rd_data_i;
        end else begin
          tail_d = bus.fifo_rd_data_i;
        end
      end
`else
      if (inflight_q) begin
        head_d = bus.fifo_rd_data_i;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
    end
  end

`ifdef FIFO_READER_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q <= '0;
    end else begin
      tail_q <= tail_d;
    end
  end
`endif

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (occ_q <= Cap) && !level[2]);

endmodule
